// File: rtl/parking_gate_ctrl.sv
// Parking entrance controller: PIN check, failed-attempt lockout
// and tailgating detection, Moore outputs from a registered state.
module parking_gate_ctrl #(
  parameter  int PIN_W     = 16,
  parameter  int MAX_TRIES = 3,
  localparam int CW        = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s01,
  input  logic             s02,
  input  logic [PIN_W-1:0] pass,
  input  logic [PIN_W-1:0] rghtpss,
  output logic             gate,
  output logic             wrong_pin_alarm,
  output logic             lock_alarm,
  output logic [CW-1:0]    tries
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] VERIFY    = 3'd1;
  localparam logic [2:0] OPEN      = 3'd2;
  localparam logic [2:0] PIN_ALARM = 3'd3;
  localparam logic [2:0] BLOCK     = 3'd4;

  localparam logic [CW-1:0] TRY_MAX  = CW'(MAX_TRIES);
  localparam logic [CW-1:0] TRY_LAST = CW'(MAX_TRIES - 1);
  localparam logic [CW-1:0] TRY_ONE  = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] tries_q, tries_d;
  logic          gate_q, wpa_q, lock_q;
  logic          match;

  assign match = (pass == rghtpss);

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    unique case (state_q)
      IDLE: begin
        if (s01 && s02) begin
          state_d = BLOCK;
        end else if (s01) begin
          state_d = VERIFY;
          tries_d = '0;
        end
      end
      VERIFY: begin
        if (match) begin
          state_d = OPEN;
          tries_d = '0;
        end else if (tries_q == TRY_LAST) begin
          state_d = PIN_ALARM;
          tries_d = TRY_MAX;
        end else begin
          tries_d = tries_q + TRY_ONE;
        end
      end
      OPEN: begin
        // tailgating outranks a normal pass-through
        if (s01 && s02) begin
          state_d = BLOCK;
        end else if (s02) begin
          state_d = IDLE;
        end
      end
      PIN_ALARM: begin
        if (match) begin
          state_d = OPEN;
          tries_d = '0;
        end
      end
      BLOCK: begin
        if (match) begin
          state_d = IDLE;
          tries_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tries_d = '0;
      end
    endcase
  end

  // outputs are registered from the next state so they change with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tries_q <= '0;
      gate_q  <= 1'b0;
      wpa_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      gate_q  <= (state_d == OPEN);
      wpa_q   <= (state_d == PIN_ALARM);
      lock_q  <= (state_d == BLOCK);
    end
  end

  assign gate            = gate_q;
  assign wrong_pin_alarm = wpa_q;
  assign lock_alarm      = lock_q;
  assign tries           = tries_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed vector bench for parking_gate_ctrl, including
// async reset and MAX_TRIES sweep sequences.
module tb_parking_gate_ctrl;

  localparam logic [15:0] PIN = 16'h2468;

  typedef struct {
    string       name;
    logic        s01;
    logic        s02;
    logic [15:0] pass;
    logic [4:0]  exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        s01, s02;
  logic [15:0] pass;
  logic [15:0] rghtpss;

  logic       g3, w3, l3;
  logic [1:0] t3;
  logic       g1, w1, l1;
  logic [0:0] t1;
  logic       g5, w5, l5;
  logic [2:0] t5;

  int n_vec;
  int n_err;
  vec_t tbl[$];

  parking_gate_ctrl #(.PIN_W(16), .MAX_TRIES(3)) dut (
    .clk(clk), .rst(rst), .s01(s01), .s02(s02),
    .pass(pass), .rghtpss(rghtpss),
    .gate(g3), .wrong_pin_alarm(w3),
    .lock_alarm(l3), .tries(t3)
  );

  parking_gate_ctrl #(.PIN_W(16), .MAX_TRIES(1)) dut1 (
    .clk(clk), .rst(rst), .s01(s01), .s02(s02),
    .pass(pass), .rghtpss(rghtpss),
    .gate(g1), .wrong_pin_alarm(w1),
    .lock_alarm(l1), .tries(t1)
  );

  parking_gate_ctrl #(.PIN_W(16), .MAX_TRIES(5)) dut5 (
    .clk(clk), .rst(rst), .s01(s01), .s02(s02),
    .pass(pass), .rghtpss(rghtpss),
    .gate(g5), .wrong_pin_alarm(w5),
    .lock_alarm(l5), .tries(t5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic b,
                      input logic [15:0] p);
    s01  = a;
    s02  = b;
    pass = p;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic a,
                     input logic b, input logic [15:0] p,
                     input logic g, input logic w,
                     input logic l, input logic [1:0] t);
    vec_t v;
    v.name = nm;
    v.s01  = a;
    v.s02  = b;
    v.pass = p;
    v.exp  = {g, w, l, t};
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    s01  = 1'b0;
    s02  = 1'b0;
    pass = 16'h0;
    rst  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rghtpss = PIN;

    // right PIN
    add("t1_verify", 1, 0, 16'h0000, 0, 0, 0, 2'd0);
    add("t1_open",   1, 0, PIN,      1, 0, 0, 2'd0);
    add("t1_pass",   0, 1, 16'h0000, 0, 0, 0, 2'd0);
    // two wrong then right
    add("t2_verify", 1, 0, 16'h4031, 0, 0, 0, 2'd0);
    add("t2_w1",     0, 0, 16'h4031, 0, 0, 0, 2'd1);
    add("t2_w2",     0, 0, 16'h4031, 0, 0, 0, 2'd2);
    add("t2_open",   0, 0, PIN,      1, 0, 0, 2'd0);
    add("t2_hold",   1, 0, 16'h0000, 1, 0, 0, 2'd0);
    add("t2_pass",   0, 1, 16'h0000, 0, 0, 0, 2'd0);
    // three wrong
    add("t3_verify", 1, 0, 16'h4027, 0, 0, 0, 2'd0);
    add("t3_w1",     0, 0, 16'h4027, 0, 0, 0, 2'd1);
    add("t3_w2",     0, 0, 16'h4027, 0, 0, 0, 2'd2);
    add("t3_alarm",  0, 0, 16'h4027, 0, 1, 0, 2'd3);
    add("t3_held",   1, 1, 16'h4027, 0, 1, 0, 2'd3);
    add("t3_open",   0, 0, PIN,      1, 0, 0, 2'd0);
    // tailgating from OPEN
    add("t4_block",  1, 1, 16'h0000, 0, 0, 1, 2'd0);
    add("t4_tog1",   0, 1, 16'h0000, 0, 0, 1, 2'd0);
    add("t4_tog2",   1, 0, 16'h0000, 0, 0, 1, 2'd0);
    add("t4_wrong",  1, 1, 16'h4031, 0, 0, 1, 2'd0);
    add("t4_clear",  0, 0, PIN,      0, 0, 0, 2'd0);
    // tailgating from IDLE beats the arrival path
    add("t4_iblock", 1, 1, PIN,      0, 0, 1, 2'd0);
    add("t4_iclear", 0, 0, PIN,      0, 0, 0, 2'd0);
    add("idle_s02",  0, 1, PIN,      0, 0, 0, 2'd0);
    // match wins in VERIFY, tailgate caught next cycle
    add("mt_verify", 1, 0, 16'h0000, 0, 0, 0, 2'd0);
    add("mt_open",   1, 1, PIN,      1, 0, 0, 2'd0);
    add("mt_block",  1, 1, 16'h0000, 0, 0, 1, 2'd0);
    add("mt_clear",  0, 0, PIN,      0, 0, 0, 2'd0);

    rst  = 1'b1;
    s01  = 1'b0;
    s02  = 1'b0;
    pass = 16'h0;
    #2;
    rst = 1'b0;
    #1;
    chk("reset", {3'b0, g3, w3, l3, t3}, 8'b0);
    do_reset();
    step(0, 0, 16'h0);
    chk("idle", {3'b0, g3, w3, l3, t3}, 8'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s01, tbl[i].s02, tbl[i].pass);
      chk(tbl[i].name, {3'b0, g3, w3, l3, t3},
          {3'b0, tbl[i].exp});
    end

    // async reset while in PIN_ALARM
    step(1, 0, 16'h4027);
    step(0, 0, 16'h4027);
    step(0, 0, 16'h4027);
    step(0, 0, 16'h4027);
    chk("ar_pa_pre", {3'b0, g3, w3, l3, t3}, 8'b0000_1011);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_pa_clr", {3'b0, g3, w3, l3, t3}, 8'b0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 16'h0);
    chk("ar_pa_idle", {3'b0, g3, w3, l3, t3}, 8'b0);
    step(1, 0, PIN);
    step(0, 0, PIN);
    chk("ar_pa_open", {3'b0, g3, w3, l3, t3}, 8'b0001_0000);

    // async reset while in BLOCK
    step(1, 1, 16'h0);
    chk("ar_bk_pre", {3'b0, g3, w3, l3, t3}, 8'b0000_0100);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_bk_clr", {3'b0, g3, w3, l3, t3}, 8'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 16'h0);
    step(0, 0, PIN);
    chk("ar_bk_open", {3'b0, g3, w3, l3, t3}, 8'b0001_0000);

    // MAX_TRIES sweep: 1 and 5
    do_reset();
    step(1, 0, 16'h0);
    chk("sw_verify1", {4'b0, g1, w1, l1, t1}, 8'b0);
    chk("sw_verify5", {2'b0, g5, w5, l5, t5}, 8'b0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 16'h4027);
      chk("sw_m1", {4'b0, g1, w1, l1, t1}, 8'b0000_0101);
      chk("sw_m5", {2'b0, g5, w5, l5, t5},
          {3'b0, 1'b0, (k == 5), 1'b0, 3'(k)});
    end
    step(0, 0, PIN);
    chk("sw_m1_open", {4'b0, g1, w1, l1, t1}, 8'b0000_1000);
    chk("sw_m5_open", {2'b0, g5, w5, l5, t5}, 8'b0010_0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
